alu_arbiter: RTL and testbench

- Shares the single combinational MIPS ALU (3-bit op, 32-bit A/B) between two requesters: port 0 (CPU execute stage) and port 1 (multiply/divide helper or debug unit).
- Latches operands, drives the ALU for a per-op latency, then returns the result to the granted requester with a one-cycle response pulse.
- Makes MUL/DIV multi-cycle for timing closure.
- Guards DIV against a zero divisor and illegal op codes.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/alu_arbiter_rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: op encodings, FSM states, per-op latency and error constants for alu_arbiter
package alu_arb_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [31:0] ERR_DIV0_RESULT = 32'hFFFF_FFFF;
  typedef enum logic {IDLE, EXEC} state_t;
  function automatic int lat_of(input logic [2:0] op, input int mul_lat, input int div_lat);
    return op == OP_MUL ? mul_lat : op == OP_DIV ? div_lat : 1;
  endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input arbiter, one-hot grant combinational from requests; ALU_ARB_RR_EN selects round-robin, else fixed priority to port 0
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       hs,
  output logic [1:0] grant
);
  logic last_grant;
  // remember which port won the most recent handshake; reset favours port 0 next
  always_ff @(posedge clk)
    if (rst) last_grant <= 1'b1;
    else if (hs) last_grant <= grant[1];
`ifdef ALU_ARB_RR_EN
  assign grant = req == 2'b11 ? (last_grant ? 2'b01 : 2'b10) : req;
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = req[0] ? 2'b01 : {req[1], 1'b0};
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational MIPS ALU between two requesters with per-op latency; ALU_ARB_RR_EN enables round-robin arbitration
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy,
  output logic [2:0]  alu_con,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result
);
  state_t state, state_nx;
  logic [1:0] grant;
  logic hs, illegal, div0, bad, owner, err_q;
  logic [2:0] sel_op, op_q;
  logic [31:0] sel_a, sel_b, a_q, b_q, err_res_q;
  logic [CNT_W-1:0] cnt;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1_valid, req0_valid} & {2{state == IDLE}}),
    .hs   (hs),
    .grant(grant)
  );
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign hs      = |grant;
  assign sel_op  = grant[1] ? req1_op : req0_op;
  assign sel_a   = grant[1] ? req1_a : req0_a;
  assign sel_b   = grant[1] ? req1_b : req0_b;
  assign illegal = sel_op > OP_SLT;
  assign div0    = sel_op == OP_DIV && sel_b == '0;
  assign bad     = illegal | div0;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: leave IDLE on a handshake, return when the latency counter expires
  always_comb
    state_nx = state == IDLE ? (hs ? EXEC : IDLE) : (cnt == '0 ? IDLE : EXEC);
  // ALU drive: latched operands only while executing, zero otherwise
  always_comb begin
    busy    = state == EXEC;
    alu_con = busy ? op_q : '0;
    alu_a   = busy ? a_q : '0;
    alu_b   = busy ? b_q : '0;
  end
  // operand capture on handshake, latency countdown, and registered response
  always_ff @(posedge clk)
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      err_q       <= 1'b0;
      err_res_q   <= '0;
      owner       <= 1'b0;
      cnt         <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      if (hs) begin
        op_q      <= bad ? '0 : sel_op;
        a_q       <= bad ? '0 : sel_a;
        b_q       <= bad ? '0 : sel_b;
        err_q     <= bad;
        err_res_q <= illegal ? '0 : ERR_DIV0_RESULT;
        owner     <= grant[1];
        cnt       <= CNT_W'(lat_of(sel_op, MUL_LAT, DIV_LAT) - 1);
      end else if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          resp_result <= err_q ? err_res_q : alu_result;
          resp_err    <= err_q;
          resp0_valid <= ~owner;
          resp1_valid <= owner;
        end
      end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven directed vectors plus hand sequences for contention, back-to-back, errors and mid-op reset
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp_err, busy;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic [2:0] alu_con;
  int tests = 0, fails = 0;
  typedef struct {
    bit port;
    logic [2:0] op;
    logic [31:0] a, b, res;
    bit err;
    int lat;
  } vec_t;
  vec_t vecs[10];
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_result(resp_result), .resp_err(resp_err),
    .busy(busy), .alu_con(alu_con), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );
  always_comb begin
    alu_result = '0;
    case (alu_con)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_a * alu_b;
      3'b011: alu_result = alu_b == 0 ? 32'd0 : alu_a / alu_b;
      3'b100: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input bit p, input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    bit hold_ok;
    logic [2:0] exp_con;
    logic [31:0] exp_a;
    exp_con = v.err ? 3'b000 : v.op;
    exp_a = v.err ? 32'd0 : v.a;
    @(negedge clk);
    drive(v.port, 1, v.op, v.a, v.b);
    #1;
    check("ready", v.port ? req1_ready : req0_ready, 1);
    @(negedge clk);
    drive(v.port, 0, 0, 0, 0);
    n = 1;
    hold_ok = 1;
    while (!(resp0_valid | resp1_valid) && n < 20) begin
      if (!busy || alu_con !== exp_con || alu_a !== exp_a) hold_ok = 0;
      @(negedge clk);
      n++;
    end
    check("latency", n, v.lat + 1);
    check("result", resp_result, v.res);
    check("err", resp_err, v.err);
    check("resp_port", resp1_valid, v.port);
    check("resp_exclusive", resp0_valid & resp1_valid, 0);
    check("alu_hold", hold_ok, 1);
    @(negedge clk);
    check("pulse_width", resp0_valid | resp1_valid, 0);
    check("result_hold", resp_result, v.res);
  endtask
  initial begin
    int c, cnt, last;
    bit saw;
    vecs[0] = '{0, OP_ADD, 5, 7, 12, 0, 1};
    vecs[1] = '{1, OP_DIV, 100, 7, 14, 0, 8};
    vecs[2] = '{0, OP_SUB, 9, 4, 5, 0, 1};
    vecs[3] = '{1, OP_SLT, 3, 8, 1, 0, 1};
    vecs[4] = '{0, OP_MUL, 6, 7, 42, 0, 3};
    vecs[5] = '{0, OP_DIV, 42, 0, 32'hFFFF_FFFF, 1, 8};
    vecs[6] = '{1, 3'b110, 11, 22, 0, 1, 1};
    vecs[7] = '{0, OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 0, 3};
    vecs[8] = '{0, OP_SUB, 0, 1, 32'hFFFF_FFFF, 0, 1};
    vecs[9] = '{1, OP_SLT, 32'hFFFF_FFFF, 1, 0, 0, 1};
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_resp", {resp1_valid, resp0_valid, resp_err}, 0);
    check("rst_result", resp_result, 0);
    check("rst_alu", {alu_con, alu_a | alu_b}, 0);
    rst = 0;
    foreach (vecs[i]) run_vec(vecs[i]);
    // port 0 blocked during a DIV, then accepted back-to-back at the response cycle
    @(negedge clk);
    drive(1, 1, OP_DIV, 100, 7);
    #1;
    check("b2b_ready1", req1_ready, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, OP_ADD, 1, 2);
    #1;
    check("ready0_in_exec", req0_ready, 0);
    repeat (7) @(negedge clk);
    check("ready0_late_exec", req0_ready, 0);
    check("div_con_late", alu_con, OP_DIV);
    @(negedge clk);
    check("b2b_resp1", resp1_valid, 1);
    check("b2b_res1", resp_result, 14);
    check("b2b_ready0", req0_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("b2b_busy", busy, 1);
    @(negedge clk);
    check("b2b_resp0", resp0_valid, 1);
    check("b2b_res0", resp_result, 3);
    // contention: both ports request continuously from a fresh reset
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(0, 1, OP_SUB, 9, 4);
    drive(1, 1, OP_SLT, 3, 8);
    c = 0; cnt = 0; last = 0;
    while (cnt < 4 && c < 40) begin
      @(negedge clk);
      c++;
      if (resp0_valid | resp1_valid) begin
`ifdef ALU_ARB_RR_EN
        check("arb_port", resp1_valid, cnt % 2);
        check("arb_res", resp_result, cnt % 2 ? 1 : 5);
`else
        check("arb_port", resp1_valid, 0);
        check("arb_res", resp_result, 5);
`endif
        if (cnt > 0) check("arb_interval", c - last, 2);
        last = c;
        cnt++;
      end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check("arb_count", cnt, 4);
    // reset during MUL execution abandons it silently
    @(negedge clk);
    drive(0, 1, OP_MUL, 6, 7);
    #1;
    check("mul_ready", req0_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mrst_busy", busy, 0);
    check("mrst_resp", {resp1_valid, resp0_valid, resp_err}, 0);
    check("mrst_result", resp_result, 0);
    check("mrst_alu", {alu_con, alu_a | alu_b}, 0);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp0_valid | resp1_valid) saw = 1;
    end
    check("mrst_no_pulse", saw, 0);
    run_vec(vecs[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
